// File: rtl/seq_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator: DIGIT bits per clock, early exit on the first
// differing digit, signed operands handled by flipping the MSB into offset-binary at latch time.
module seq_mag_comp #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             L,
    output logic             E,
    output logic             G
);
    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("seq_mag_comp: WIDTH must be a multiple of DIGIT");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("seq_mag_comp: WIDTH must be at least 2");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             l_q, l_d, e_q, e_d, g_q, g_d;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [DIGIT-1:0] da, db;
    logic [WIDTH-1:0] msb_flip;

    assign a_sh     = a_q >> (k_q * DIGIT);
    assign b_sh     = b_q >> (k_q * DIGIT);
    assign da       = a_sh[DIGIT-1:0];
    assign db       = b_sh[DIGIT-1:0];
    assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            l_q     <= l_d;
            e_q     <= e_d;
            g_q     <= g_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        l_d     = l_q;
        e_d     = e_q;
        g_d     = g_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Offset-binary: flipping the sign bit makes signed order match unsigned order.
                    a_d     = A ^ msb_flip;
                    b_d     = B ^ msb_flip;
                    k_d     = KW'(N - 1);
                    busy_d  = 1'b1;
                    l_d     = 1'b0;
                    e_d     = 1'b0;
                    g_d     = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (da != db) begin
                    l_d     = (da < db);
                    g_d     = (da > db);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (k_q == '0) begin
                    e_d     = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign L    = l_q;
    assign E    = e_q;
    assign G    = g_q;
endmodule
